// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller beside the ID stage: load-use, branch, imem and dmem stalls.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue, hazard rules evaluated every cycle
// LU       | cycle after a load-use bubble; RUN rules re-applied
// MEM_WAIT | data memory busy, front end frozen, branch redirect may pend
// IF_WAIT  | instruction memory not ready, IF/ID fed NOPs
module hazard_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs2,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rd,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_busy,
    output logic        PC_write,
    output logic        IF_stall,
    output logic        IF_flush,
    output logic        ID_bubble,
    output logic        hang_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {RUN, LU, MEM_WAIT, IF_WAIT} state_t;

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              pend_flush, pend_nxt;
    logic              load_use;
    logic              br_flush;
    logic              pc_write_c, stall_c, flush_c, bubble_c;
    logic              in_wait, to_wait;

    assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                      ((EX_rd == ID_rs1) || (ID_uses_rs2 && (EX_rd == ID_rs2)));

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend_flush;
        pc_write_c = 1'b1;
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        br_flush   = 1'b0;
        case (state)
            RUN, LU: begin
                pend_nxt = 1'b0;
                if (dmem_busy) begin
                    pc_write_c = 1'b0;
                    stall_c    = 1'b1;
                    pend_nxt   = branch_taken;
                    state_nxt  = MEM_WAIT;
                end else if (load_use) begin
                    // branch operands not valid yet, so a same-cycle branch is dropped
                    pc_write_c = 1'b0;
                    stall_c    = 1'b1;
                    bubble_c   = 1'b1;
                    state_nxt  = LU;
                end else if (branch_taken) begin
                    flush_c   = 1'b1;
                    br_flush  = 1'b1;
                    state_nxt = RUN;
                end else if (!imem_ready) begin
                    pc_write_c = 1'b0;
                    flush_c    = 1'b1;
                    state_nxt  = IF_WAIT;
                end else begin
                    state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_write_c = 1'b0;
                    stall_c    = 1'b1;
                    pend_nxt   = pend_flush | branch_taken;
                end else begin
                    flush_c   = pend_flush | branch_taken;
                    br_flush  = pend_flush | branch_taken;
                    pend_nxt  = 1'b0;
                    state_nxt = RUN;
                end
            end
            IF_WAIT: begin
                pend_nxt = 1'b0;
                if (dmem_busy) begin
                    pc_write_c = 1'b0;
                    flush_c    = 1'b1;
                    state_nxt  = MEM_WAIT;
                end else if (!imem_ready) begin
                    pc_write_c = 1'b0;
                    flush_c    = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                pend_nxt  = 1'b0;
                state_nxt = RUN;
            end
        endcase
    end

    assign in_wait = (state == MEM_WAIT) || (state == IF_WAIT);
    assign to_wait = (state_nxt == MEM_WAIT) || (state_nxt == IF_WAIT);

    always_comb begin
        wait_nxt = wait_cnt;
        if (!to_wait) begin
            wait_nxt = '0;
        end else if (in_wait && (wait_cnt != MAX_CNT)) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            pend_flush <= 1'b0;
            hang_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            pend_flush <= pend_nxt;
            hang_err   <= hang_err | (wait_nxt == MAX_CNT);
        end
    end

    // flush always wins over stall
    assign PC_write  = ~rst & pc_write_c;
    assign IF_flush  = rst | flush_c;
    assign IF_stall  = ~rst & stall_c & ~flush_c;
    assign ID_bubble = rst | bubble_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write_c) stall_q <= stall_q + 32'd1;
            if (br_flush)    flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    logic perf_unused;
    assign perf_unused  = br_flush;
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan sequences plus random traffic,
// checked against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1, ID_rs2, EX_rd;
    logic        ID_uses_rs2, EX_MemRead, branch_taken, imem_ready, dmem_busy;
    logic        PC_write, IF_stall, IF_flush, ID_bubble, hang_err;
    logic [31:0] stall_cycles, flush_count;

    hazard_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs2(ID_uses_rs2),
        .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
        .PC_write(PC_write), .IF_stall(IF_stall), .IF_flush(IF_flush), .ID_bubble(ID_bubble),
        .hang_err(hang_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  ctrl;   // PC_write, IF_stall, IF_flush, ID_bubble, hang_err
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // reference model: front end frozen on memory, fetch starved, pending redirect
    bit          m_frozen, m_starved, m_pend, m_hang;
    int          m_wait_len;
    logic [31:0] m_stalls, m_flushes;

    function automatic void model_reset();
        m_frozen = 0; m_starved = 0; m_pend = 0; m_hang = 0;
        m_wait_len = 0; m_stalls = 0; m_flushes = 0;
    endfunction

    function automatic void model_step();
        bit pc = 1, st = 0, fl = 0, bu = 0;
        bit was_waiting, is_waiting, hazard;
        exp_t e;
        if (rst) begin
            e.ctrl = {1'b0, 1'b0, 1'b1, 1'b1, m_hang};
            e.sc = PERF ? m_stalls : 32'd0;
            e.fc = PERF ? m_flushes : 32'd0;
            exp_q.push_back(e);
            model_reset();
            return;
        end
        hazard = EX_MemRead && EX_rd != 0 &&
                 (EX_rd == ID_rs1 || (ID_uses_rs2 && EX_rd == ID_rs2));
        was_waiting = m_frozen || m_starved;
        e.sc = PERF ? m_stalls : 32'd0;
        e.fc = PERF ? m_flushes : 32'd0;
        e.ctrl[0] = m_hang;
        if (m_frozen) begin
            if (dmem_busy) begin
                pc = 0; st = 1; m_pend = m_pend | branch_taken;
            end else begin
                fl = m_pend | branch_taken;
                if (fl) m_flushes++;
                m_pend = 0; m_frozen = 0;
            end
        end else if (m_starved) begin
            if (dmem_busy) begin
                pc = 0; fl = 1; m_starved = 0; m_frozen = 1; m_pend = 0;
            end else if (!imem_ready) begin
                pc = 0; fl = 1;
            end else begin
                m_starved = 0;
            end
        end else begin
            if (dmem_busy) begin
                pc = 0; st = 1; m_frozen = 1; m_pend = branch_taken;
            end else if (hazard) begin
                pc = 0; st = 1; bu = 1;
            end else if (branch_taken) begin
                fl = 1; m_flushes++;
            end else if (!imem_ready) begin
                pc = 0; fl = 1; m_starved = 1;
            end
        end
        if (!pc) m_stalls++;
        is_waiting = m_frozen || m_starved;
        if (!is_waiting) m_wait_len = 0;
        else if (was_waiting && m_wait_len < MAXW) m_wait_len++;
        if (m_wait_len == MAXW) m_hang = 1;
        e.ctrl[4:1] = {pc, st & ~fl, fl, bu};
        exp_q.push_back(e);
    endfunction

    task automatic drive(input bit r, input bit busy, input bit imr, input bit br,
                         input bit mr, input int rd, input int rs1, input int rs2, input bit u2);
        rst = r; dmem_busy = busy; imem_ready = imr; branch_taken = br;
        EX_MemRead = mr; EX_rd = 5'(rd); ID_rs1 = 5'(rs1); ID_rs2 = 5'(rs2); ID_uses_rs2 = u2;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0, 0, 1, 2, 0);
    endtask

    // monitor: outputs are sampled mid-cycle, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({PC_write, IF_stall, IF_flush, ID_bubble, hang_err} === e.ctrl) passed++;
                else $display("FAIL ctrl t=%0t got pc/stall/flush/bubble/hang=%b want=%b",
                              $time, {PC_write, IF_stall, IF_flush, ID_bubble, hang_err}, e.ctrl);
                checks++;
                if (stall_cycles === e.sc && flush_count === e.fc) passed++;
                else $display("FAIL counters t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                              $time, stall_cycles, flush_count, e.sc, e.fc);
            end
        end
    end

    initial begin
        int budget;
        model_reset();
        rst = 1; dmem_busy = 0; imem_ready = 1; branch_taken = 0;
        EX_MemRead = 0; EX_rd = 0; ID_rs1 = 0; ID_rs2 = 0; ID_uses_rs2 = 0;
        @(posedge clk); #1;
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);          // reset outputs, registers already cleared
        idle(2);
        // load-use on rs1, then rd=0 must not stall
        drive(0, 0, 1, 0, 1, 5, 5, 1, 0);
        idle(1);
        drive(0, 0, 1, 0, 1, 0, 0, 1, 0);
        // rs2 gating
        drive(0, 0, 1, 0, 1, 7, 1, 7, 0);
        drive(0, 0, 1, 0, 1, 7, 1, 7, 1);
        idle(1);
        // branch during dmem_busy
        drive(0, 1, 1, 0, 0, 0, 1, 2, 0);
        drive(0, 1, 1, 1, 0, 0, 1, 2, 0);
        drive(0, 1, 1, 0, 0, 0, 1, 2, 0);
        idle(2);
        // imem wait
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, 2, 0);
        idle(2);
        // watchdog
        for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 0, 0, 1, 2, 0);
        idle(3);
        drive(1, 0, 1, 0, 0, 0, 1, 2, 0);
        idle(2);
        // reset mid-wait with a pending redirect
        drive(0, 1, 1, 1, 0, 0, 1, 2, 0);
        drive(0, 1, 1, 0, 0, 0, 1, 2, 0);
        drive(1, 1, 1, 0, 0, 0, 1, 2, 0);
        idle(2);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) != 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1);
        end
        idle(1);
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage core.
- Produces the stall/flush controls consumed by the IF/ID pipeline register (IF_stall, IF_flush), the PC write enable, and the ID/EX bubble select.
- Sources: load-use hazards, branches resolved in ID, instruction-memory not-ready, and data-memory busy.
- Small FSM plus wait watchdog; sits beside the ID stage.

Parameters:
- MAX_WAIT, 64: cycles allowed in a wait state before the watchdog flags hang_err.
- WAIT_W, 7: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ID_rs1  in  5  rs1 index of the instruction in ID
- ID_rs2  in  5  rs2 index of the instruction in ID
- ID_uses_rs2  in  1  instruction in ID reads rs2
- EX_MemRead  in  1  instruction in EX is a load
- EX_rd  in  5  destination of the instruction in EX
- branch_taken  in  1  branch/jump resolved taken in ID this cycle
- imem_ready  in  1  instruction memory returns a valid word this cycle
- dmem_busy  in  1  data memory cannot complete this cycle
- PC_write  out  1  1 = PC updates
- IF_stall  out  1  1 = IF/ID holds its contents
- IF_flush  out  1  1 = IF/ID loads PC=0, instruction=0 (NOP)
- ID_bubble  out  1  1 = ID/EX control fields forced to 0
- hang_err  out  1  sticky watchdog error
- stall_cycles  out  32  performance counter (see Optional Feature)
- flush_count  out  32  performance counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset state: state=RUN, wait_cnt=0, pend_flush=0, hang_err=0, counters=0.
- Outputs while rst=1: PC_write=0, IF_stall=0, IF_flush=1, ID_bubble=1.
- Output type: all control outputs are combinational from the current state and inputs, with 0-cycle latency. State updates on the rising edge of clk.
- load_use = EX_MemRead & (EX_rd!=0) & ((EX_rd==ID_rs1) | (ID_uses_rs2 & EX_rd==ID_rs2)).
- Default outputs: PC_write=1, all other controls 0.
- States and priority in RUN (highest first):
  1. dmem_busy: PC_write=0, IF_stall=1, ID_bubble=0 (whole front end frozen). Next state MEM_WAIT. pend_flush <= branch_taken.
  2. load_use: PC_write=0, IF_stall=1, ID_bubble=1. Next state LU. A branch_taken in the same cycle is ignored, since the branch operands are not valid yet.
  3. branch_taken: PC_write=1, IF_flush=1. Stay in RUN. flush_count increments.
  4. !imem_ready: PC_write=0, IF_flush=1. Next state IF_WAIT.
- LU:
  - Exactly one cycle with outputs equal to the defaults.
  - Re-evaluates the RUN rules using the LU-cycle inputs, so a second load-use or a branch is handled normally.
- MEM_WAIT:
  - PC_write=0, IF_stall=1.
  - pend_flush |= branch_taken.
  - Exit when dmem_busy=0 → RUN. In the exit cycle, if pend_flush=1: IF_flush=1, flush_count increments, pend_flush <= 0.
- IF_WAIT:
  - PC_write=0, IF_flush=1.
  - dmem_busy=1 has priority → MEM_WAIT.
  - imem_ready=1 → RUN with default outputs that cycle.
- Simultaneous IF_stall and IF_flush: never both 1 in the same cycle. Flush wins; the stall is dropped.
- Watchdog:
  - wait_cnt increments each cycle spent in MEM_WAIT or IF_WAIT and clears on entry to RUN/LU.
  - When wait_cnt reaches MAX_WAIT, hang_err is set. It is cleared only by rst.
  - wait_cnt saturates at MAX_WAIT; there is no wrap-around.
- Reset mid-wait: rst aborts any state immediately at the next edge. pend_flush is discarded.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cycles increments every cycle with PC_write=0 and rst=0.
  - flush_count increments on every IF_flush caused by a branch (direct or pending).
  - Both counters are 32-bit wrapping and cleared by rst.
- When undefined: both outputs are tied to 0 and no counter flops are synthesized.

Test Plan:
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs1=5 → 1 cycle PC_write=0, IF_stall=1, ID_bubble=1, then defaults; with EX_rd=0 → no stall.
- rs2 gating: EX_MemRead=1, EX_rd=7, ID_rs2=7, ID_uses_rs2=0 → no stall; ID_uses_rs2=1 → stall.
- Branch during dmem_busy: dmem_busy=1 for 3 cycles with branch_taken=1 in cycle 2 → IF_stall=1 for 3 cycles, then IF_flush=1 for exactly 1 cycle; flush_count=1 (macro on).
- IMEM wait: imem_ready=0 for 4 cycles → IF_flush=1, PC_write=0 for 4 cycles; stall_cycles=4; return to RUN.
- Watchdog: MAX_WAIT=8, dmem_busy held 20 cycles → hang_err=1 from the 9th wait cycle and still 1 after dmem_busy drops; rst clears it.
- Reset mid-wait: rst=1 during MEM_WAIT with pend_flush=1 → next cycle state=RUN, no pending flush issued, counters=0.
